// File: rtl/caliptra_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_sync_debounce
// Brief    : Counter-based debounce of a synchronized level, with edge
//            pulses, a sticky change flag and a pending-change indicator.
// Revision : 1.0
// ============================================================================
module caliptra_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    input  logic clr_sticky,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic event_sticky,
    output logic busy
);

    localparam int              c_CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1
                                        : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_dout;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rise;
    logic               r_fall;
    logic               r_sticky;

    logic w_diff;
    logic w_accept;

    assign w_diff   = (din != r_dout);
    // The >= guard keeps the counter from ever passing its terminal value.
    assign w_accept = en && w_diff && (r_cnt >= c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout   <= RST_VAL;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_rise <= w_accept && din;
            r_fall <= w_accept && !din;

            if (!en || !w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt  <= '0;
                r_dout <= din;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign dout         = r_dout;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign event_sticky = r_sticky;
    assign busy         = en && w_diff;

endmodule
`default_nettype wire

// File: tb/tb_caliptra_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_caliptra_sync_debounce
// Brief    : Directed self-checking bench for caliptra_sync_debounce.
// Revision : 1.0
// ============================================================================
module tb_caliptra_sync_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: DEBOUNCE_CYCLES=4, RST_VAL=0
    logic din_a = 1'b0, en_a = 1'b0, clr_a = 1'b0;
    logic dout_a, rise_a, fall_a, stk_a, busy_a;
    // Instance B: DEBOUNCE_CYCLES=4, RST_VAL=1
    logic din_b = 1'b0, en_b = 1'b0, clr_b = 1'b0;
    logic dout_b, rise_b, fall_b, stk_b, busy_b;
    // Instance C: DEBOUNCE_CYCLES=1, RST_VAL=0
    logic din_c = 1'b0, en_c = 1'b0, clr_c = 1'b0;
    logic dout_c, rise_c, fall_c, stk_c, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    caliptra_sync_debounce #(.DEBOUNCE_CYCLES(4), .RST_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din_a), .en(en_a), .clr_sticky(clr_a),
        .dout(dout_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .event_sticky(stk_a), .busy(busy_a));

    caliptra_sync_debounce #(.DEBOUNCE_CYCLES(4), .RST_VAL(1'b1)) dut_r1 (
        .clk(clk), .rst(rst), .din(din_b), .en(en_b), .clr_sticky(clr_b),
        .dout(dout_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .event_sticky(stk_b), .busy(busy_b));

    caliptra_sync_debounce #(.DEBOUNCE_CYCLES(1), .RST_VAL(1'b0)) dut_d1 (
        .clk(clk), .rst(rst), .din(din_c), .en(en_c), .clr_sticky(clr_c),
        .dout(dout_c), .rise_pulse(rise_c), .fall_pulse(fall_c),
        .event_sticky(stk_c), .busy(busy_c));

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en_a = 1'b1; din_a = 1'b1;
        do_reset();
        tick(2);
        rst = 1'b1;
        #1;
        checks++;
        if (dout_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0 || stk_a !== 1'b0) begin
            errors++; $display("FAIL reset_a: dout/rise/fall/stk got %b%b%b%b expected 0000",
                               dout_a, rise_a, fall_a, stk_a);
        end
        checks++;
        if (dut.r_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt_async: got %0d expected 0", dut.r_cnt);
        end
        checks++;
        if (dout_b !== 1'b1 || stk_b !== 1'b0) begin
            errors++; $display("FAIL reset_b: dout/stk got %b%b expected 10", dout_b, stk_b);
        end
        din_a = 1'b0; en_a = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_rise();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++; $display("FAIL rise_busy: got %b expected 1", busy_a);
        end
        tick(3);
        checks++;
        if (dout_a !== 1'b0 || rise_a !== 1'b0) begin
            errors++; $display("FAIL rise_early: dout/rise got %b%b expected 00", dout_a, rise_a);
        end
        tick(1);
        checks++;
        if (dout_a !== 1'b1 || rise_a !== 1'b1 || fall_a !== 1'b0 || stk_a !== 1'b1) begin
            errors++; $display("FAIL rise_accept: dout/rise/fall/stk got %b%b%b%b expected 1101",
                               dout_a, rise_a, fall_a, stk_a);
        end
        tick(1);
        checks++;
        if (dout_a !== 1'b1 || rise_a !== 1'b0 || stk_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL rise_after: dout/rise/stk/busy got %b%b%b%b expected 1010",
                               dout_a, rise_a, stk_a, busy_a);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        tick(3);
        checks++;
        if (dout_a !== 1'b0 || busy_a !== 1'b1 || dut.r_cnt !== 3'd3) begin
            errors++; $display("FAIL glitch_hold: dout/busy got %b%b cnt %0d expected 01 cnt 3",
                               dout_a, busy_a, dut.r_cnt);
        end
        din_a = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL glitch_busy: got %b expected 0", busy_a);
        end
        tick(1);
        checks++;
        if (dout_a !== 1'b0 || rise_a !== 1'b0 || stk_a !== 1'b0 || dut.r_cnt !== 3'd0) begin
            errors++; $display("FAIL glitch_reject: dout/rise/stk got %b%b%b cnt %0d expected 000 cnt 0",
                               dout_a, rise_a, stk_a, dut.r_cnt);
        end
    endtask

    task automatic test_en_restart();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        tick(5);
        din_a = 1'b0;
        tick(1);
        en_a = 1'b0;
        tick(1);
        checks++;
        if (dut.r_cnt !== 3'd0 || dout_a !== 1'b1 || fall_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL en_off: cnt %0d dout/fall/busy got %b%b%b expected cnt 0 100",
                               dut.r_cnt, dout_a, fall_a, busy_a);
        end
        en_a = 1'b1;
        tick(3);
        checks++;
        if (dout_a !== 1'b1 || fall_a !== 1'b0) begin
            errors++; $display("FAIL en_restart_early: dout/fall got %b%b expected 10", dout_a, fall_a);
        end
        tick(1);
        checks++;
        if (dout_a !== 1'b0 || fall_a !== 1'b1 || rise_a !== 1'b0) begin
            errors++; $display("FAIL en_restart_fall: dout/fall/rise got %b%b%b expected 010",
                               dout_a, fall_a, rise_a);
        end
        tick(1);
        checks++;
        if (fall_a !== 1'b0) begin
            errors++; $display("FAIL en_fall_width: got %b expected 0", fall_a);
        end
    endtask

    task automatic test_sticky_clr();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        tick(3);
        clr_a = 1'b1;
        tick(1);
        checks++;
        if (stk_a !== 1'b1 || dout_a !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins: stk/dout got %b%b expected 11", stk_a, dout_a);
        end
        tick(1);
        checks++;
        if (stk_a !== 1'b0) begin
            errors++; $display("FAIL sticky_clear: got %b expected 0", stk_a);
        end
        clr_a = 1'b0;
        tick(1);
        checks++;
        if (stk_a !== 1'b0) begin
            errors++; $display("FAIL sticky_stays_clear: got %b expected 0", stk_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        tick(4);
        din_a = 1'b0;
        tick(1);
        checks++;
        if (dut.r_cnt !== 3'd1 || rise_a !== 1'b0 || dout_a !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: cnt %0d rise/dout %b%b expected cnt 1 01",
                               dut.r_cnt, rise_a, dout_a);
        end
        tick(3);
        checks++;
        if (dout_a !== 1'b0 || fall_a !== 1'b1) begin
            errors++; $display("FAIL b2b_fall: dout/fall got %b%b expected 01", dout_a, fall_a);
        end
    endtask

    task automatic test_rst_midcount();
        do_reset();
        en_a = 1'b1; din_a = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        checks++;
        if (dout_a !== 1'b0 || dut.r_cnt !== 3'd0) begin
            errors++; $display("FAIL rst_mid: dout %b cnt %0d expected 0 cnt 0", dout_a, dut.r_cnt);
        end
        tick(1);
        rst = 1'b0;
        tick(3);
        checks++;
        if (dout_a !== 1'b0 || rise_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_recount: dout/rise got %b%b expected 00", dout_a, rise_a);
        end
        tick(1);
        checks++;
        if (dout_a !== 1'b1 || rise_a !== 1'b1) begin
            errors++; $display("FAIL rst_mid_accept: dout/rise got %b%b expected 11", dout_a, rise_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rise_a !== 1'b0 || dout_a !== 1'b0 || stk_a !== 1'b0) begin
            errors++; $display("FAIL rst_on_pulse: rise/dout/stk got %b%b%b expected 000",
                               rise_a, dout_a, stk_a);
        end
        en_a = 1'b0; din_a = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_rstval1();
        en_b = 1'b1; din_b = 1'b0;
        do_reset();
        checks++;
        if (dout_b !== 1'b1 || fall_b !== 1'b0 || rise_b !== 1'b0) begin
            errors++; $display("FAIL rv1_release: dout/fall/rise got %b%b%b expected 100",
                               dout_b, fall_b, rise_b);
        end
        tick(3);
        checks++;
        if (dout_b !== 1'b1 || fall_b !== 1'b0) begin
            errors++; $display("FAIL rv1_early: dout/fall got %b%b expected 10", dout_b, fall_b);
        end
        tick(1);
        checks++;
        if (dout_b !== 1'b0 || fall_b !== 1'b1 || stk_b !== 1'b1) begin
            errors++; $display("FAIL rv1_fall: dout/fall/stk got %b%b%b expected 011",
                               dout_b, fall_b, stk_b);
        end
        en_b = 1'b0;
    endtask

    task automatic test_d1_toggle();
        logic v;
        en_c = 1'b1; din_c = 1'b0;
        do_reset();
        v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din_c = v;
            tick(1);
            checks++;
            if (dout_c !== v || rise_c !== v || fall_c !== !v) begin
                errors++; $display("FAIL d1_toggle[%0d]: dout/rise/fall got %b%b%b expected %b%b%b",
                                   i, dout_c, rise_c, fall_c, v, v, !v);
            end
            v = !v;
        end
        en_c = 1'b0;
    endtask

    initial begin
        tick(2);
        test_reset();
        test_rise();
        test_glitch();
        test_en_restart();
        test_sticky_clr();
        test_back_to_back();
        test_rst_midcount();
        test_rstval1();
        test_d1_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
